sp_sram_arb_ctrl: RTL and testbench

- Controller and arbiter that shares one single-port SRAM macro (active-low ceb/web/bwb, registered dout) between two requesters, r0 and r1.
- After reset, it zero-initialises the whole array.
- It then grants at most one access per cycle using round-robin priority and returns read data one cycle after the accepted read.
- It sits between FIFO/buffer logic and the sp SRAM instance.

---
 rtl/sp_sram_arb_ctrl_if.sv | 53 +++++
 rtl/sp_sram_arb_ctrl.sv | 109 ++++++++++
 tb/tb_sp_sram_arb_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sp_sram_arb_ctrl_if.sv
// rtl/sp_sram_arb_ctrl_if.sv - requester and SRAM macro signal bundle for sp_sram_arb_ctrl
// slave is the controller's view; master is the requester/SRAM side.
interface sp_sram_arb_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 10
);
  logic                  init_done;

  logic                  r0_valid;
  logic                  r0_ready;
  logic                  r0_we;
  logic [ADDR_WIDTH-1:0] r0_addr;
  logic [DATA_WIDTH-1:0] r0_wdata;
  logic [DATA_WIDTH-1:0] r0_wmask;
  logic                  r0_rvalid;
  logic [DATA_WIDTH-1:0] r0_rdata;

  logic                  r1_valid;
  logic                  r1_ready;
  logic                  r1_we;
  logic [ADDR_WIDTH-1:0] r1_addr;
  logic [DATA_WIDTH-1:0] r1_wdata;
  logic [DATA_WIDTH-1:0] r1_wmask;
  logic                  r1_rvalid;
  logic [DATA_WIDTH-1:0] r1_rdata;

  logic                  mem_ceb;
  logic                  mem_web;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_bwb;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport slave (
    output init_done,
    input  r0_valid, r0_we, r0_addr, r0_wdata, r0_wmask,
    output r0_ready, r0_rvalid, r0_rdata,
    input  r1_valid, r1_we, r1_addr, r1_wdata, r1_wmask,
    output r1_ready, r1_rvalid, r1_rdata,
    output mem_ceb, mem_web, mem_addr, mem_din, mem_bwb,
    input  mem_dout
  );

  modport master (
    input  init_done,
    output r0_valid, r0_we, r0_addr, r0_wdata, r0_wmask,
    input  r0_ready, r0_rvalid, r0_rdata,
    output r1_valid, r1_we, r1_addr, r1_wdata, r1_wmask,
    input  r1_ready, r1_rvalid, r1_rdata,
    input  mem_ceb, mem_web, mem_addr, mem_din, mem_bwb,
    output mem_dout
  );
endinterface

// File: rtl/sp_sram_arb_ctrl.sv
// rtl/sp_sram_arb_ctrl.sv - round-robin two-requester controller for a single-port SRAM
// Zero-fills the array after reset, then grants one access per cycle with 1-cycle read latency.
module sp_sram_arb_ctrl #(
  parameter int MEM_DEPTH  = 12,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 10,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  sp_sram_arb_ctrl_if.slave bus
);
  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MEM_DEPTH - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  rr_ptr;
  logic                  rd_pend0, rd_pend1, rd_oor0, rd_oor1;

  logic                  grant0, grant1, in_range;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata, sel_wmask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT_EN ? S_INIT : S_RUN;
      cnt      <= '0;
      rr_ptr   <= 1'b0;
      rd_pend0 <= 1'b0;
      rd_pend1 <= 1'b0;
      rd_oor0  <= 1'b0;
      rd_oor1  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (grant0) begin
        rr_ptr <= 1'b1;
      end else if (grant1) begin
        rr_ptr <= 1'b0;
      end
      rd_pend0 <= grant0 & ~bus.r0_we;
      rd_pend1 <= grant1 & ~bus.r1_we;
      rd_oor0  <= grant0 & ~bus.r0_we & ~in_range;
      rd_oor1  <= grant1 & ~bus.r1_we & ~in_range;
    end
  end

  // Everything is forced idle while rst is high so the macro never sees a stray access.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    grant0       = 1'b0;
    grant1       = 1'b0;
    sel_we       = 1'b0;
    sel_addr     = '0;
    sel_wdata    = '0;
    sel_wmask    = '0;
    in_range     = 1'b0;
    bus.r0_ready = 1'b0;
    bus.r1_ready = 1'b0;
    bus.mem_ceb  = 1'b1;
    bus.mem_web  = 1'b1;
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    bus.mem_bwb  = '1;
    if (!rst) begin
      if (state == S_INIT) begin
        bus.mem_ceb  = 1'b0;
        bus.mem_web  = 1'b0;
        bus.mem_bwb  = '0;
        bus.mem_addr = cnt;
        cnt_nxt      = cnt + ADDR_WIDTH'(1);
        if (cnt == LAST_IDX) begin
          state_nxt = S_RUN;
        end
      end else begin
        grant0 = bus.r0_valid && (!bus.r1_valid || !rr_ptr);
        grant1 = bus.r1_valid && !grant0;
        bus.r0_ready = grant0;
        bus.r1_ready = grant1;
        sel_we    = grant0 ? bus.r0_we    : bus.r1_we;
        sel_addr  = grant0 ? bus.r0_addr  : bus.r1_addr;
        sel_wdata = grant0 ? bus.r0_wdata : bus.r1_wdata;
        sel_wmask = grant0 ? bus.r0_wmask : bus.r1_wmask;
        in_range  = {1'b0, sel_addr} < DEPTH_W;
        // Out-of-range requests are accepted but never reach the macro.
        if ((grant0 || grant1) && in_range) begin
          bus.mem_ceb  = 1'b0;
          bus.mem_addr = sel_addr;
          if (sel_we) begin
            bus.mem_web = 1'b0;
            bus.mem_din = sel_wdata;
            bus.mem_bwb = ~sel_wmask;
          end
        end
      end
    end
  end

  assign bus.init_done = (state == S_RUN) && !rst;
  assign bus.r0_rvalid = rd_pend0 && !rst;
  assign bus.r1_rvalid = rd_pend1 && !rst;
  assign bus.r0_rdata  = (bus.r0_rvalid && !rd_oor0) ? bus.mem_dout : '0;
  assign bus.r1_rdata  = (bus.r1_rvalid && !rd_oor1) ? bus.mem_dout : '0;
endmodule

// File: tb/tb_sp_sram_arb_ctrl.sv
// tb/tb_sp_sram_arb_ctrl.sv - directed vector bench for sp_sram_arb_ctrl
// Two DUTs share rst: u_dut (INIT_EN=1) and u_dut_ni (INIT_EN=0), each with its own SRAM model.
module tb_sp_sram_arb_ctrl;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  sp_sram_arb_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(10)) ifa ();
  sp_sram_arb_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(10)) ifb ();

  sp_sram_arb_ctrl #(.MEM_DEPTH(12), .ADDR_WIDTH(4), .DATA_WIDTH(10), .INIT_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  sp_sram_arb_ctrl #(.MEM_DEPTH(12), .ADDR_WIDTH(4), .DATA_WIDTH(10), .INIT_EN(1'b0)) u_dut_ni (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  logic [9:0] mem_a [0:15] = '{10'h2A5, 10'h2A4, 10'h2A7, 10'h2A6, 10'h2A1, 10'h2A0, 10'h2A3, 10'h2A2,
                               10'h2AD, 10'h2AC, 10'h2AF, 10'h2AE, 10'h2A9, 10'h2A8, 10'h2AB, 10'h2AA};
  logic [9:0] mem_b [0:15] = '{10'h001, 10'h004, 10'h007, 10'h00A, 10'h00D, 10'h010, 10'h013, 10'h016,
                               10'h019, 10'h01C, 10'h01F, 10'h022, 10'h025, 10'h028, 10'h02B, 10'h02E};

  always @(posedge clk) begin
    if (!ifa.mem_ceb) begin
      if (!ifa.mem_web) mem_a[ifa.mem_addr] <= (mem_a[ifa.mem_addr] & ifa.mem_bwb) | (ifa.mem_din & ~ifa.mem_bwb);
      else              ifa.mem_dout <= mem_a[ifa.mem_addr];
    end
  end

  always @(posedge clk) begin
    if (!ifb.mem_ceb) begin
      if (!ifb.mem_web) mem_b[ifb.mem_addr] <= (mem_b[ifb.mem_addr] & ifb.mem_bwb) | (ifb.mem_din & ~ifb.mem_bwb);
      else              ifb.mem_dout <= mem_b[ifb.mem_addr];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r0v; logic r0we; logic [3:0] r0a; logic [9:0] r0wd; logic [9:0] r0wm;
    logic       r1v; logic r1we; logic [3:0] r1a; logic [9:0] r1wd; logic [9:0] r1wm;
    logic       rdy0; logic rdy1;
    logic       ceb; logic web; logic [3:0] addr; logic [9:0] bwb; logic [9:0] din;
    logic       rv0; logic [9:0] rd0; logic rv1; logic [9:0] rd1;
  } vec_t;

  vec_t vt [0:15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input vec_t v);
    ifa.r0_valid = v.r0v; ifa.r0_we = v.r0we; ifa.r0_addr = v.r0a; ifa.r0_wdata = v.r0wd; ifa.r0_wmask = v.r0wm;
    ifa.r1_valid = v.r1v; ifa.r1_we = v.r1we; ifa.r1_addr = v.r1a; ifa.r1_wdata = v.r1wd; ifa.r1_wmask = v.r1wm;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    // r0v,we,a,wd,wm | r1v,we,a,wd,wm | rdy0,rdy1 | ceb,web,addr,bwb,din | rv0,rd0,rv1,rd1
    vt[0]  = '{0,0,4'h0,10'h000,10'h000, 0,0,4'h0,10'h000,10'h000, 0,0, 1,1,4'h0,10'h3FF,10'h000, 1,10'h000, 0,10'h000};
    vt[1]  = '{1,1,4'h3,10'h3FF,10'h00F, 0,0,4'h0,10'h000,10'h000, 1,0, 0,0,4'h3,10'h3F0,10'h3FF, 0,10'h000, 0,10'h000};
    vt[2]  = '{1,0,4'h3,10'h000,10'h000, 0,0,4'h0,10'h000,10'h000, 1,0, 0,1,4'h3,10'h3FF,10'h000, 0,10'h000, 0,10'h000};
    vt[3]  = '{0,0,4'h0,10'h000,10'h000, 0,0,4'h0,10'h000,10'h000, 0,0, 1,1,4'h0,10'h3FF,10'h000, 1,10'h00F, 0,10'h000};
    vt[4]  = '{0,0,4'h0,10'h000,10'h000, 1,1,4'h2,10'h155,10'h3FF, 0,1, 0,0,4'h2,10'h000,10'h155, 0,10'h000, 0,10'h000};
    vt[5]  = '{1,0,4'h1,10'h000,10'h000, 1,0,4'h2,10'h000,10'h000, 1,0, 0,1,4'h1,10'h3FF,10'h000, 0,10'h000, 0,10'h000};
    vt[6]  = '{1,0,4'h1,10'h000,10'h000, 1,0,4'h2,10'h000,10'h000, 0,1, 0,1,4'h2,10'h3FF,10'h000, 1,10'h000, 0,10'h000};
    vt[7]  = '{1,0,4'h1,10'h000,10'h000, 1,0,4'h2,10'h000,10'h000, 1,0, 0,1,4'h1,10'h3FF,10'h000, 0,10'h000, 1,10'h155};
    vt[8]  = '{1,0,4'h1,10'h000,10'h000, 1,0,4'h2,10'h000,10'h000, 0,1, 0,1,4'h2,10'h3FF,10'h000, 1,10'h000, 0,10'h000};
    vt[9]  = '{0,0,4'h0,10'h000,10'h000, 1,0,4'hD,10'h000,10'h000, 0,1, 1,1,4'h0,10'h3FF,10'h000, 0,10'h000, 1,10'h155};
    vt[10] = '{0,0,4'h0,10'h000,10'h000, 1,1,4'hC,10'h3FF,10'h3FF, 0,1, 1,1,4'h0,10'h3FF,10'h000, 0,10'h000, 1,10'h000};
    vt[11] = '{0,0,4'h0,10'h000,10'h000, 1,0,4'hB,10'h000,10'h000, 0,1, 0,1,4'hB,10'h3FF,10'h000, 0,10'h000, 0,10'h000};
    vt[12] = '{1,1,4'h5,10'h2AA,10'h3FF, 1,0,4'h5,10'h000,10'h000, 1,0, 0,0,4'h5,10'h000,10'h2AA, 0,10'h000, 1,10'h000};
    vt[13] = '{1,0,4'h5,10'h000,10'h000, 1,0,4'h5,10'h000,10'h000, 0,1, 0,1,4'h5,10'h3FF,10'h000, 0,10'h000, 0,10'h000};
    vt[14] = '{1,0,4'h5,10'h000,10'h000, 0,0,4'h0,10'h000,10'h000, 1,0, 0,1,4'h5,10'h3FF,10'h000, 0,10'h000, 1,10'h2AA};
    vt[15] = '{0,0,4'h0,10'h000,10'h000, 0,0,4'h0,10'h000,10'h000, 0,0, 1,1,4'h0,10'h3FF,10'h000, 1,10'h2AA, 0,10'h000};

    drive_a(vt[0]);
    ifb.r0_valid = 0; ifb.r0_we = 0; ifb.r0_addr = 0; ifb.r0_wdata = 0; ifb.r0_wmask = 0;
    ifb.r1_valid = 0; ifb.r1_we = 0; ifb.r1_addr = 0; ifb.r1_wdata = 0; ifb.r1_wmask = 0;
    ifa.r0_valid = 1'b1;
    rst = 1'b1;
    next_cycle();
    next_cycle();

    @(negedge clk);
    chk("rst init_done", 32'(ifa.init_done), 32'd0);
    chk("rst r0_ready", 32'(ifa.r0_ready), 32'd0);
    chk("rst mem_ceb", 32'(ifa.mem_ceb), 32'd1);
    chk("rst mem_web", 32'(ifa.mem_web), 32'd1);
    chk("rst mem_bwb", 32'(ifa.mem_bwb), 32'h3FF);
    chk("rst mem_addr", 32'(ifa.mem_addr), 32'd0);
    chk("rst mem_din", 32'(ifa.mem_din), 32'd0);
    chk("rst r0_rvalid", 32'(ifa.r0_rvalid), 32'd0);
    chk("rst ni init_done", 32'(ifb.init_done), 32'd0);
    next_cycle();
    rst = 1'b0;

    // Init sweep; the INIT_EN=0 instance is exercised in parallel on cycles 0 and 1.
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        ifb.r0_valid = 1'b1;
        ifb.r0_addr  = 4'h0;
      end else begin
        ifb.r0_valid = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("init%0d mem_ceb", i), 32'(ifa.mem_ceb), 32'd0);
      chk($sformatf("init%0d mem_web", i), 32'(ifa.mem_web), 32'd0);
      chk($sformatf("init%0d mem_bwb", i), 32'(ifa.mem_bwb), 32'd0);
      chk($sformatf("init%0d mem_din", i), 32'(ifa.mem_din), 32'd0);
      chk($sformatf("init%0d mem_addr", i), 32'(ifa.mem_addr), 32'(i));
      chk($sformatf("init%0d r0_ready", i), 32'(ifa.r0_ready), 32'd0);
      chk($sformatf("init%0d init_done", i), 32'(ifa.init_done), 32'd0);
      if (i == 0) begin
        chk("ni init_done", 32'(ifb.init_done), 32'd1);
        chk("ni r0_ready", 32'(ifb.r0_ready), 32'd1);
        chk("ni mem_ceb", 32'(ifb.mem_ceb), 32'd0);
      end
      if (i == 1) begin
        chk("ni r0_rvalid", 32'(ifb.r0_rvalid), 32'd1);
        chk("ni r0_rdata", 32'(ifb.r0_rdata), 32'h001);
      end
      next_cycle();
    end

    @(negedge clk);
    chk("run init_done", 32'(ifa.init_done), 32'd1);
    chk("run r0_ready", 32'(ifa.r0_ready), 32'd1);
    chk("run mem_ceb", 32'(ifa.mem_ceb), 32'd0);
    chk("run mem_addr", 32'(ifa.mem_addr), 32'd0);
    next_cycle();

    for (int i = 0; i < 16; i++) begin
      drive_a(vt[i]);
      @(negedge clk);
      chk($sformatf("row%0d r0_ready", i), 32'(ifa.r0_ready), 32'(vt[i].rdy0));
      chk($sformatf("row%0d r1_ready", i), 32'(ifa.r1_ready), 32'(vt[i].rdy1));
      chk($sformatf("row%0d mem_ceb", i), 32'(ifa.mem_ceb), 32'(vt[i].ceb));
      if (!vt[i].ceb) begin
        chk($sformatf("row%0d mem_web", i), 32'(ifa.mem_web), 32'(vt[i].web));
        chk($sformatf("row%0d mem_addr", i), 32'(ifa.mem_addr), 32'(vt[i].addr));
        chk($sformatf("row%0d mem_bwb", i), 32'(ifa.mem_bwb), 32'(vt[i].bwb));
        chk($sformatf("row%0d mem_din", i), 32'(ifa.mem_din), 32'(vt[i].din));
      end
      chk($sformatf("row%0d r0_rvalid", i), 32'(ifa.r0_rvalid), 32'(vt[i].rv0));
      chk($sformatf("row%0d r0_rdata", i), 32'(ifa.r0_rdata), 32'(vt[i].rd0));
      chk($sformatf("row%0d r1_rvalid", i), 32'(ifa.r1_rvalid), 32'(vt[i].rv1));
      chk($sformatf("row%0d r1_rdata", i), 32'(ifa.r1_rdata), 32'(vt[i].rd1));
      next_cycle();
    end

    // Reset the cycle after an accepted read: the response must be dropped.
    ifa.r0_valid = 1'b1; ifa.r0_we = 1'b0; ifa.r0_addr = 4'h3;
    @(negedge clk);
    chk("midrst r0_ready", 32'(ifa.r0_ready), 32'd1);
    next_cycle();
    ifa.r0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst r0_rvalid", 32'(ifa.r0_rvalid), 32'd0);
    chk("midrst mem_ceb", 32'(ifa.mem_ceb), 32'd1);
    chk("midrst init_done", 32'(ifa.init_done), 32'd0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("reinit%0d mem_addr", i), 32'(ifa.mem_addr), 32'(i));
      chk($sformatf("reinit%0d r0_rvalid", i), 32'(ifa.r0_rvalid), 32'd0);
      next_cycle();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("cnt5 rst mem_ceb", 32'(ifa.mem_ceb), 32'd1);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("restart%0d mem_addr", i), 32'(ifa.mem_addr), 32'(i));
      chk($sformatf("restart%0d init_done", i), 32'(ifa.init_done), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("restart init_done", 32'(ifa.init_done), 32'd1);
    chk("restart r0_rvalid", 32'(ifa.r0_rvalid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
